// File: rtl/div_32_32.sv
// div_32_32 -- iterative radix-2 restoring divider, sign-magnitude.
//
// Computes quotient and remainder of div_a / div_b, one quotient bit per
// cycle, with truncating (C-style) signed semantics. A zero divisor
// short-circuits straight to DONE with quo = all ones and rem = div_a.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   div_flush         (only with DIV_FLUSH_EN) sync abort back to IDLE
//   div_valid/ready   request handshake; ready only in IDLE
//   div_signed        1 = two's-complement operands
//   div_a, div_b      dividend, divisor
//   div_out_valid/ready  result handshake
//   div_quo, div_rem  result; held until the next result loads
//   div_by_zero       current result came from a zero divisor
//
// Optional feature macro: DIV_FLUSH_EN (adds div_flush).
module div_32_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DIV_FLUSH_EN
  input  logic             div_flush,
`endif
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  output logic             div_out_valid,
  input  logic             div_out_ready,
  output logic [WIDTH-1:0] div_quo,
  output logic [WIDTH-1:0] div_rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             a_neg_q, b_neg_q;
  logic [WIDTH-1:0] dvd_q;   // dividend, shifts out MSB-first; quotient shifts in at LSB
  logic [WIDTH-1:0] dvs_q;   // |divisor|
  logic [WIDTH-1:0] prem_q;  // partial remainder, always < |divisor|
  logic             ready_q, out_valid_q, dbz_q;
  logic [WIDTH-1:0] quo_q, rem_q;

  // operand magnitudes at the accept edge
  logic             a_neg_d, b_neg_d;
  logic [WIDTH-1:0] a_mag_d, b_mag_d;

  always_comb begin
    a_neg_d = div_signed & div_a[WIDTH-1];
    b_neg_d = div_signed & div_b[WIDTH-1];
    a_mag_d = a_neg_d ? (~div_a + 1'b1) : div_a;
    b_mag_d = b_neg_d ? (~div_b + 1'b1) : div_b;
  end

  // one restoring step; shifted needs WIDTH+1 bits since 2*prem can exceed 2^WIDTH-1
  logic [WIDTH:0]   shifted_d, diff_d;
  logic             qbit_d;
  logic [WIDTH-1:0] prem_d, dvd_d;

  always_comb begin
    shifted_d = {prem_q, dvd_q[WIDTH-1]};
    diff_d    = shifted_d - {1'b0, dvs_q};
    qbit_d    = ~diff_d[WIDTH];
    prem_d    = qbit_d ? diff_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    dvd_d     = {dvd_q[WIDTH-2:0], qbit_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
    end else begin
`ifdef DIV_FLUSH_EN
      if (div_flush) begin
        // flush wins over accept and handoff; result registers untouched
        state_q     <= IDLE;
        ready_q     <= 1'b1;
        out_valid_q <= 1'b0;
      end else
`endif
      case (state_q)
        IDLE: if (div_valid) begin
          a_neg_q <= a_neg_d;
          b_neg_q <= b_neg_d;
          dvd_q   <= a_mag_d;
          dvs_q   <= b_mag_d;
          prem_q  <= '0;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          if (div_b == '0) begin
            quo_q       <= '1;
            rem_q       <= div_a;
            dbz_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_q <= FIX;
        end
        FIX: begin
          // -2^(W-1) / -1 yields magnitude 2^(W-1); negating it wraps back to itself
          quo_q       <= (a_neg_q ^ b_neg_q) ? (~dvd_q + 1'b1) : dvd_q;
          rem_q       <= a_neg_q ? (~prem_q + 1'b1) : prem_q;
          dbz_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (div_out_ready) begin
          out_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_ready     = ready_q;
  assign div_out_valid = out_valid_q;
  assign div_quo       = quo_q;
  assign div_rem       = rem_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_div_32_32.sv
// tb_div_32_32 -- table-driven plus random checks of div_32_32, with an
// expected-result queue filled at accept and drained at handoff.
module tb_div_32_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_valid, div_ready, div_signed;
  logic [31:0] div_a, div_b;
  logic        div_out_valid, div_out_ready;
  logic [31:0] div_quo, div_rem;
  logic        div_by_zero;
`ifdef DIV_FLUSH_EN
  logic        div_flush;
`endif

  always #5 clk = ~clk;

  div_32_32 #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef DIV_FLUSH_EN
    .div_flush    (div_flush),
`endif
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_signed   (div_signed),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_out_valid(div_out_valid),
    .div_out_ready(div_out_ready),
    .div_quo      (div_quo),
    .div_rem      (div_rem),
    .div_by_zero  (div_by_zero)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] q, r;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] q, r;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[14];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // independent reference: SV integer division on 64-bit values
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint la, lb;
    if (b == 0) begin
      e.q = '1; e.r = a; e.z = 1'b1; e.lat = 1;
    end else begin
      la = s ? longint'($signed(a)) : longint'({32'd0, a});
      lb = s ? longint'($signed(b)) : longint'({32'd0, b});
      e.q = 32'(la / lb);
      e.r = 32'(la % lb);
      e.z = 1'b0; e.lat = 34;
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e);
    int w = 0;
    @(negedge clk);
    div_valid = 1'b1; div_a = a; div_b = b; div_signed = s;
    while (!div_ready && w < 100) begin @(negedge clk); w++; end
    chk("ready_before_accept", {31'd0, div_ready}, 32'd1);
    @(posedge clk); #1;
    div_valid = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic collect(input int hold);
    int          lat = 1;
    exp_t        e;
    logic [31:0] q0, r0;
    while (!div_out_valid && lat < 200) begin
      div_a = $urandom; div_b = $urandom; div_signed = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("valid_timeout", {31'd0, div_out_valid}, 32'd1);
    q0 = div_quo; r0 = div_rem;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, div_out_valid}, 32'd1);
      chk("hold_quo", div_quo, q0);
      chk("hold_rem", div_rem, r0);
    end
    chk("ready_in_done", {31'd0, div_ready}, 32'd0);
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("quo", div_quo, e.q);
      chk("rem", div_rem, e.r);
      chk("dbz", {31'd0, div_by_zero}, {31'd0, e.z});
      chk("latency", lat, e.lat);
    end
    div_out_ready = 1'b1;
    @(posedge clk); #1;
    div_out_ready = 1'b0;
    chk("valid_after_take", {31'd0, div_out_valid}, 32'd0);
    chk("ready_after_take", {31'd0, div_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    exp_t e;
    e.q = v.q; e.r = v.r; e.z = v.z; e.lat = (v.b == 0) ? 1 : 34;
    send(v.a, v.b, v.s, e);
    collect(hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    exp_t        e;
    vec_t        v;

    vt[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vt[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vt[2]  = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vt[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
    vt[4]  = '{32'hFFFF_FFFF,  32'h10,         1'b0, 32'h0FFF_FFFF,  32'hF,          1'b0};
    vt[5]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
    vt[6]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0};
    vt[7]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
    vt[8]  = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0};
    vt[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};
    vt[10] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
    vt[11] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'd1,          32'd0,          1'b0};
    vt[12] = '{32'h8000_0000,  32'd2,          1'b0, 32'h4000_0000,  32'd0,          1'b0};
    vt[13] = '{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          1'b0};

    rst_n = 1'b0; div_valid = 1'b0; div_signed = 1'b0; div_a = '0; div_b = '0;
    div_out_ready = 1'b0;
`ifdef DIV_FLUSH_EN
    div_flush = 1'b0;
`endif
    #12;
    chk("rst_ready", {31'd0, div_ready}, 32'd1);
    chk("rst_valid", {31'd0, div_out_valid}, 32'd0);
    chk("rst_quo", div_quo, 32'd0);
    chk("rst_rem", div_rem, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vt[i], 0);

    // backpressure, then back-to-back request right after the handoff
    run_vec(vt[0], 10);
    run_vec(vt[1], 0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = (i % 4 == 0) ? ($urandom >> 20) : $urandom;
      if (i == 5) rb = 0;
      rs = 1'($urandom);
      e  = model(ra, rb, rs);
      send(ra, rb, rs, e);
      collect(i % 3);
    end

    // reset in the middle of CALC (iteration 10)
    send(32'd1000, 32'd3, 1'b0, model(32'd1000, 32'd3, 1'b0));
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, div_out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, div_ready}, 32'd1);
    chk("midrst_quo", div_quo, 32'd0);
    void'(sbq.pop_back());
    @(negedge clk); rst_n = 1'b1;
    run_vec(vt[4], 0);

`ifdef DIV_FLUSH_EN
    send(32'd1000, 32'd3, 1'b0, model(32'd1000, 32'd3, 1'b0));
    void'(sbq.pop_back());
    repeat (5) @(posedge clk);
    @(negedge clk); div_flush = 1'b1;
    @(posedge clk); #1 div_flush = 1'b0;
    chk("flush_valid", {31'd0, div_out_valid}, 32'd0);
    chk("flush_ready", {31'd0, div_ready}, 32'd1);
    chk("flush_quo_kept", div_quo, 32'h0FFF_FFFF);
    v = vt[0];
    run_vec(v, 0);
`endif

    chk("sb_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_32_32.md
Name: div_32_32

Overview:
Iterative 32/32 integer divider, the inverse operation of the team's combinational booth/wallace multiplier mul_32_32. It shares the same operand width and sits beside mul_32_32 in the arithmetic unit. It computes quotient and remainder one bit per cycle (radix-2 restoring) on a sign-magnitude basis. Operands come in, and results go out, over valid/ready handshakes.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits. Must be even and at least 4.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
div_valid  input  1  operand request valid
div_ready  output  1  block can accept a request (high only in IDLE)
div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
div_a  input  WIDTH  dividend
div_b  input  WIDTH  divisor
div_out_valid  output  1  result valid
div_out_ready  input  1  consumer accepts result
div_quo  output  WIDTH  quotient
div_rem  output  WIDTH  remainder
div_by_zero  output  1  flag: the current result came from a zero divisor

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state = IDLE
  - div_ready = 1
  - div_out_valid = 0
  - div_quo = 0, div_rem = 0, div_by_zero = 0
  - iteration counter = 0
- Reset mid-operation aborts the operation immediately; there is no partial output.
- States: IDLE, CALC, FIX, DONE.
- IDLE: div_ready = 1.
  - Accept when div_valid && div_ready at a clock edge.
  - Latch div_signed, the operand signs, |div_a| and |div_b|. Magnitudes come from a conditional two's-complement negate when signed and the MSB is set.
  - Divisor == 0: go to DONE. div_quo = all ones, div_rem = div_a (raw), div_by_zero = 1. Result is valid 1 cycle after accept.
  - Otherwise: go to CALC with counter = 0 and partial remainder = 0.
- CALC: one quotient bit per cycle, MSB first.
  - Shift {prem, dividend} left by 1 and trial-subtract |divisor| from the WIDTH+1-bit prem.
  - If the result is non-negative, keep the difference and set the quotient bit to 1. Otherwise restore and set the quotient bit to 0.
  - After WIDTH iterations (counter == WIDTH-1), go to FIX.
- FIX:
  - Negate the quotient if signed and the operand signs differ.
  - Negate the remainder if signed and the dividend is negative (remainder takes the sign of the dividend; truncating division).
  - Go to DONE.
- DONE: div_out_valid = 1, and outputs stay stable until div_out_valid && div_out_ready. On that edge go to IDLE, with div_out_valid falling the same edge.
- div_ready is 0 in CALC, FIX and DONE. A new request cannot be accepted in the same cycle a result is taken; it is accepted at the earliest one cycle later.
- Latency for a non-zero divisor: div_out_valid rises WIDTH+2 cycles after the accept edge (34 for WIDTH=32). Throughput is one division per WIDTH+3 cycles minimum.
- Signed overflow (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1) (0x8000_0000), remainder = 0, div_by_zero = 0, normal latency. This falls out naturally from the WIDTH-bit magnitude and negate path.
- div_a/div_b/div_signed are ignored outside the accept edge; input changes during CALC have no effect.
- div_quo/div_rem/div_by_zero keep the last result after handoff until the next result loads.

Optional Feature:
Macro DIV_FLUSH_EN.
- Defined: adds input port div_flush (1 bit, synchronous). When high at a clock edge in any state, the block goes to IDLE and div_out_valid = 0. Result registers are left unchanged and any in-flight division is discarded. A flush has priority over an accept or a result handoff in the same cycle.
- Undefined: the port and its logic are absent, and a division always runs to DONE.

Test Plan:
- Unsigned 100/7: div_a=100, div_b=7, div_signed=0 -> after 34 cycles quo=14, rem=2, div_by_zero=0.
- Signed -7/2: div_a=0xFFFF_FFF9, div_b=2, div_signed=1 -> quo=0xFFFF_FFFD (-3), rem=0xFFFF_FFFF (-1).
- Divide by zero: div_a=0x1234_5678, div_b=0 -> valid 1 cycle after accept, quo=0xFFFF_FFFF, rem=0x1234_5678, div_by_zero=1.
- Signed overflow: div_a=0x8000_0000, div_b=0xFFFF_FFFF, div_signed=1 -> quo=0x8000_0000, rem=0.
- Backpressure: hold div_out_ready=0 for 10 cycles after valid -> outputs stable and div_ready=0. Raise div_out_ready -> a back-to-back request is accepted one cycle after the handoff.
- Reset mid-CALC: assert rst_n=0 at iteration 10 -> div_out_valid=0 and div_ready=1 immediately. The next request 0xFFFF_FFFF/0x10 (unsigned) gives quo=0x0FFF_FFFF, rem=0xF.
